// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Provides the clear/run state type and the address-width helper.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by alloc, cleared by writes, flushed by clear.
// Ports: clk, rst_n, flush, set_en/set_addr, clr_en/clr_addr (NW ports), busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NW    = 1,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               set_en,
    input  logic [AW-1:0]      set_addr,
    input  logic [NW-1:0]      clr_en,
    input  logic [NW*AW-1:0]   clr_addr,
    output logic [DEPTH-1:0]   busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Set is applied after clears so a same-cycle alloc wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (clr_en[p]) begin
                    busy_d[clr_addr[p*AW +: AW]] = 1'b0;
                end
            end
            if (set_en) begin
                busy_d[set_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NR comb reads, NW writes with bypass, PC alias,
// busy scoreboard and sequential clear. Ports: clk, rst_n, clr_req, ready,
// we/wa/wd, ra/rd/rd_rdy, pc_val, alloc_en/alloc_addr.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int W      = 32,
    parameter int DEPTH  = 16,
    parameter int NR     = 2,
    parameter int NW     = 1,
    parameter int PC_IDX = 15,
    localparam int AW    = rf_aw(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_req,
    output logic               ready,
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   wa,
    input  logic [NW*W-1:0]    wd,
    input  logic [NR*AW-1:0]   ra,
    output logic [NR*W-1:0]    rd,
    output logic [NR-1:0]      rd_rdy,
    input  logic [W-1:0]       pc_val,
    input  logic               alloc_en,
    input  logic [AW-1:0]      alloc_addr
);

    localparam logic [AW-1:0] PC_A  = AW'(PC_IDX);
    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

    rf_state_t         state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;

    logic [W-1:0]      rf_q [DEPTH];
    logic [W-1:0]      rf_d [DEPTH];

    logic              run;
    logic [NW-1:0]     we_eff;
    logic              set_en;
    logic              flush;
    logic [DEPTH-1:0]  busy;

    assign run    = (state_q == RF_RUN);
    assign set_en = run && alloc_en && (alloc_addr != PC_A);
    assign flush  = run && clr_req;
    assign ready  = ready_q;

    // Writes to the PC alias are dropped entirely (no data, no busy clear).
    always_comb begin
        we_eff = '0;
        for (int p = 0; p < NW; p++) begin
            we_eff[p] = run && we[p] && (wa[p*AW +: AW] != PC_A);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        unique case (state_q)
            RF_CLEAR: begin
                if (clr_cnt_q == LAST_A) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            RF_RUN: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_cnt_d = '0;
                    ready_d   = 1'b0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Higher write ports overwrite lower ones on an address collision.
    always_comb begin
        rf_d = rf_q;
        if (!run) begin
            rf_d[clr_cnt_q] = '0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (we_eff[p]) begin
                    rf_d[wa[p*AW +: AW]] = wd[p*W +: W];
                end
            end
        end
    end

    // Array contents are not reset; the clear engine zeroes them.
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NW    (NW),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .set_en   (set_en),
        .set_addr (alloc_addr),
        .clr_en   (we_eff),
        .clr_addr (wa),
        .busy     (busy)
    );

    for (genvar r = 0; r < NR; r++) begin : g_rd
        logic [AW-1:0] ra_r;
        logic [W-1:0]  rd_v;
        logic          rdy_v;

        assign ra_r = ra[r*AW +: AW];

        // Ascending scan leaves the highest matching write port in place.
        always_comb begin
            rd_v  = '0;
            rdy_v = 1'b0;
            if (run) begin
                if (ra_r == PC_A) begin
                    rd_v  = pc_val;
                    rdy_v = 1'b1;
                end else begin
                    rd_v  = rf_q[ra_r];
                    rdy_v = !busy[ra_r];
                    for (int p = 0; p < NW; p++) begin
                        if (we_eff[p] && (wa[p*AW +: AW] == ra_r)) begin
                            rd_v  = wd[p*W +: W];
                            rdy_v = 1'b1;
                        end
                    end
                end
            end
        end

        assign rd[r*W +: W] = rd_v;
        assign rd_rdy[r]    = rdy_v;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports.
// Checks clear timing, bypass, PC alias, busy tracking and reset restart.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        ready;
    logic [1:0]  we;
    logic [7:0]  wa;
    logic [63:0] wd;
    logic [7:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_rdy;
    logic [31:0] pc_val;
    logic        alloc_en;
    logic [3:0]  alloc_addr;

    int n_chk;
    int n_err;
    int n;

    regfile_mp #(
        .W      (32),
        .DEPTH  (16),
        .NR     (2),
        .NW     (2),
        .PC_IDX (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .ready      (ready),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .ra         (ra),
        .rd         (rd),
        .rd_rdy     (rd_rdy),
        .pc_val     (pc_val),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we       = '0;
        alloc_en = 1'b0;
        clr_req  = 1'b0;
    endtask

    // Count edges until ready rises; rd must stay zero meanwhile.
    task automatic wait_ready(input string tag, input int already);
        n = already;
        while (!ready && n < 40) begin
            chk({tag, "_rd0"}, rd[31:0], 32'h0);
            chk({tag, "_rdy0"}, 32'(rd_rdy), 32'h0);
            tick();
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'd16);
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        clr_req    = 1'b0;
        we         = '0;
        wa         = '0;
        wd         = '0;
        ra         = '0;
        pc_val     = 32'h108;
        alloc_en   = 1'b0;
        alloc_addr = '0;

        #12;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rd", rd[63:32], 32'h0);
        #5;
        rst_n = 1'b1;
        #1;
        wait_ready("clr", 0);

        for (int i = 0; i < 15; i++) begin
            ra = {4'(i), 4'(i)};
            #1;
            chk($sformatf("zero%0d", i), rd[31:0], 32'h0);
            chk($sformatf("zrdy%0d", i), 32'(rd_rdy), 32'h3);
        end

        // Bypass then array read
        we = 2'b01; wa = 8'h03; wd = {32'h0, 32'h2710}; ra = 8'hf3;
        #1;
        chk("byp_rd", rd[31:0], 32'h2710);
        chk("byp_rdy", 32'(rd_rdy[0]), 32'h1);
        tick(); idle();
        chk("arr_rd", rd[31:0], 32'h2710);

        // PC alias
        chk("pc_rd", rd[63:32], 32'h108);
        chk("pc_rdy", 32'(rd_rdy[1]), 32'h1);
        we = 2'b01; wa = 8'h0f; wd = {32'h0, 32'hff};
        #1;
        chk("pc_wr_byp", rd[63:32], 32'h108);
        tick(); idle();
        pc_val = 32'h200;
        #1;
        chk("pc_after", rd[63:32], 32'h200);

        // Alloc then write clears busy
        alloc_en = 1'b1; alloc_addr = 4'd5; ra = 8'h05;
        #1;
        chk("alloc_pre", 32'(rd_rdy[0]), 32'h1);
        tick(); idle();
        chk("alloc_busy", 32'(rd_rdy[0]), 32'h0);
        we = 2'b01; wa = 8'h05; wd = {32'h0, 32'hab};
        #1;
        chk("wb_byp", rd[31:0], 32'hab);
        chk("wb_rdy", 32'(rd_rdy[0]), 32'h1);
        tick(); idle();
        chk("wb_arr", rd[31:0], 32'hab);
        chk("wb_free", 32'(rd_rdy[0]), 32'h1);

        // Same-cycle alloc and write: alloc wins, data written
        alloc_en = 1'b1; alloc_addr = 4'd6;
        we = 2'b10; wa = 8'h60; wd = {32'h66, 32'h0};
        tick(); idle();
        ra = 8'h06;
        #1;
        chk("aw_data", rd[31:0], 32'h66);
        chk("aw_busy", 32'(rd_rdy[0]), 32'h0);

        // Both ports to address 7: port 1 wins
        we = 2'b11; wa = 8'h77; wd = {32'h22, 32'h11}; ra = 8'h07;
        #1;
        chk("dual_byp", rd[31:0], 32'h22);
        tick(); idle();
        chk("dual_arr", rd[31:0], 32'h22);
        we = 2'b11; wa = 8'h98; wd = {32'h99, 32'h88};
        tick(); idle();
        ra = 8'h98;
        #1;
        chk("dual_a", rd[31:0], 32'h88);
        chk("dual_b", rd[63:32], 32'h99);

        // clr_req with same-cycle write and a pending busy bit
        alloc_en = 1'b1; alloc_addr = 4'd10;
        tick(); idle();
        ra = 8'hba;
        #1;
        chk("cr_busy", 32'(rd_rdy[0]), 32'h0);
        clr_req = 1'b1; we = 2'b01; wa = 8'h0b; wd = {32'h0, 32'hbeef};
        tick(); idle();
        chk("cr_ready", 32'(ready), 32'h0);
        wait_ready("creq", 0);
        #1;
        chk("cr_free", 32'(rd_rdy[0]), 32'h1);
        chk("cr_rd10", rd[31:0], 32'h0);
        chk("cr_rd11", rd[63:32], 32'h0);

        // Reset mid-run, then a second pulse at clear cycle 8
        alloc_en = 1'b1; alloc_addr = 4'd12;
        we = 2'b01; wa = 8'h0d; wd = {32'h0, 32'h1313};
        tick(); idle();
        ra = 8'hdc;
        #1;
        chk("pre_busy", 32'(rd_rdy[0]), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_ready", 32'(ready), 32'h0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        wait_ready("rst8", 0);
        #1;
        chk("rst_free", 32'(rd_rdy[0]), 32'h1);
        chk("rst_rd12", rd[31:0], 32'h0);
        chk("rst_rd13", rd[63:32], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
